// File: rtl/axil_char_pkg.sv
// Shared types and helpers for the AXI-Lite character writer.
// Holds the FSM state encoding, the AXI response code and byte-lane helpers.
package axil_char_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL_AR,
        ST_POLL_R,
        ST_WR,
        ST_RESP
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Byte strobe for a single-byte write at the given address offset.
    function automatic logic [3:0] lane_strb(input logic [1:0] offset);
        return 4'b0001 << offset;
    endfunction

    // The same byte on all four lanes, so the slave sees it whatever its lane.
    function automatic logic [31:0] lane_replicate(input logic [7:0] data);
        return {4{data}};
    endfunction

endpackage

// File: rtl/axil_char_fifo.sv
// Byte FIFO buffering characters in front of the AXI-Lite write engine.
// Pointers carry one extra wrap bit so full and empty are told apart.
module axil_char_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone say
    // which entries are valid, so the array can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Full comes from registered pointers only, so a same-cycle pop never frees a slot early.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axil_char_writer.sv
// AXI-Lite initiator draining a byte stream into a UART TX register, one
// single-beat write per byte, optionally gated by a status-register poll.
module axil_char_writer
    import axil_char_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [4:0]  TX_OFFSET    = 5'h04,
    parameter logic [4:0]  STAT_OFFSET  = 5'h08,
    parameter int          STAT_RDY_BIT = 2,
    parameter bit          POLL_EN      = 1'b1,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // AXI-Lite write address channel
    output logic        axi_aw_valid,
    input  logic        axi_aw_ready,
    output logic [31:0] axi_aw_addr,
    output logic [2:0]  axi_aw_prot,
    // AXI-Lite write data channel
    output logic        axi_w_valid,
    input  logic        axi_w_ready,
    output logic [31:0] axi_w_data,
    output logic [3:0]  axi_w_strb,
    // AXI-Lite write response channel
    input  logic        axi_b_valid,
    output logic        axi_b_ready,
    input  logic [1:0]  axi_b_resp,
    // AXI-Lite read address channel
    output logic        axi_ar_valid,
    input  logic        axi_ar_ready,
    output logic [31:0] axi_ar_addr,
    output logic [2:0]  axi_ar_prot,
    // AXI-Lite read data channel
    input  logic        axi_r_valid,
    output logic        axi_r_ready,
    input  logic [31:0] axi_r_data,
    input  logic [1:0]  axi_r_resp,
    // Character stream and status
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] tx_count
);

    localparam logic [31:0] TX_ADDR   = BASE_ADDR + 32'(TX_OFFSET);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'(STAT_OFFSET);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_aw_valid;
    logic        r_w_valid;
    logic        r_ar_valid;
    logic        r_b_ready;
    logic        r_r_ready;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_w_data;
    logic        r_err;
    logic [15:0] r_tx_count;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_have_byte;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_b_hs;
    logic        w_aw_done_next;
    logic        w_w_done_next;
    logic        w_enter_wr;
    logic        w_unused_rdata;

    assign w_push = char_valid & ~w_fifo_full;
    assign w_pop  = w_b_hs;

    axil_char_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_data (char_data),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    assign w_aw_hs = r_aw_valid & axi_aw_ready;
    assign w_w_hs  = r_w_valid & axi_w_ready;
    assign w_ar_hs = r_ar_valid & axi_ar_ready;
    assign w_r_hs  = r_r_ready & axi_r_valid;
    assign w_b_hs  = r_b_ready & axi_b_valid;

    // A push into an empty FIFO launches the transaction on the same edge it is stored.
    assign w_have_byte = ~w_fifo_empty | w_push;

    // Per-channel completion as it will stand after this edge.
    assign w_aw_done_next = (r_state == ST_WR) & (r_aw_done | w_aw_hs);
    assign w_w_done_next  = (r_state == ST_WR) & (r_w_done | w_w_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: the default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for the next-state value.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_have_byte) w_state_next = POLL_EN ? ST_POLL_AR : ST_WR;
            end
            ST_POLL_AR: begin
                if (w_ar_hs) w_state_next = ST_POLL_R;
            end
            ST_POLL_R: begin
                if (w_r_hs) w_state_next = axi_r_data[STAT_RDY_BIT] ? ST_WR : ST_POLL_AR;
            end
            ST_WR: begin
                if (w_aw_done_next && w_w_done_next) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (w_b_hs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_wr = (r_state != ST_WR) && (w_state_next == ST_WR);

    // Handshake outputs are registered copies of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_b_ready  <= 1'b0;
            r_r_ready  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_w_data   <= '0;
        end else begin
            r_ar_valid <= (w_state_next == ST_POLL_AR);
            r_r_ready  <= (w_state_next == ST_POLL_R);
            r_b_ready  <= (w_state_next == ST_RESP);
            r_aw_done  <= (w_state_next == ST_WR) & w_aw_done_next;
            r_w_done   <= (w_state_next == ST_WR) & w_w_done_next;
            r_aw_valid <= (w_state_next == ST_WR) & ~w_aw_done_next;
            r_w_valid  <= (w_state_next == ST_WR) & ~w_w_done_next;
            // An empty FIFO means the byte is being pushed this very edge.
            if (w_enter_wr) r_w_data <= lane_replicate(w_fifo_empty ? char_data : w_head);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_tx_count <= '0;
        end else begin
            if (w_b_hs) begin
                r_tx_count <= r_tx_count + 16'd1;
                if (axi_b_resp != AXI_RESP_OKAY) r_err <= 1'b1;
            end
            if (w_r_hs && (axi_r_resp != AXI_RESP_OKAY)) r_err <= 1'b1;
        end
    end

    assign w_unused_rdata = &{1'b0, axi_r_data};

    assign axi_aw_valid = r_aw_valid;
    assign axi_aw_addr  = TX_ADDR;
    assign axi_aw_prot  = 3'b000;
    assign axi_w_valid  = r_w_valid;
    assign axi_w_data   = r_w_data;
    assign axi_w_strb   = lane_strb(TX_OFFSET[1:0]);
    assign axi_b_ready  = r_b_ready;
    assign axi_ar_valid = r_ar_valid;
    assign axi_ar_addr  = STAT_ADDR;
    assign axi_ar_prot  = 3'b000;
    assign axi_r_ready  = r_r_ready;

    assign char_ready = ~w_fifo_full;
    assign busy       = ~w_fifo_empty | (r_state != ST_IDLE);
    assign err        = r_err;
    assign tx_count   = r_tx_count;

endmodule

// File: doc/axil_char_writer.md
# axil_char_writer

AXI-Lite initiator that drains a byte stream into a memory-mapped UART transmit register. Bytes arrive on a valid/ready input and are buffered in a small FIFO. Each byte becomes one AXI-Lite single-beat write to `BASE_ADDR + TX_OFFSET`, optionally preceded by a status-register poll. It sits between the core's debug/print path and the UART slave on the peripheral AXI-Lite bus, and it is the bus-master counterpart of the UART slave.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: UART base address.
- `TX_OFFSET`, 5'h04: TX data register offset.
- `STAT_OFFSET`, 5'h08: status register offset.
- `STAT_RDY_BIT`, 2: status bit index meaning "TX can accept".
- `POLL_EN`, 1: 1 polls status before every write; 0 writes blindly.
- `FIFO_DEPTH`, 4: byte buffer depth; power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `axi`, `AXI_LITE.Master`, bus: AXI-Lite initiator port.
- `char_valid`, in, 1: input byte valid.
- `char_data`, in, 8: input byte.
- `char_ready`, out, 1: FIFO not full.
- `busy`, out, 1: FIFO non-empty or FSM not IDLE.
- `err`, out, 1: sticky; set on any non-OKAY BRESP or RRESP.
- `tx_count`, out, 16: number of completed write transactions; wraps 16'hFFFF→0.

## Operation
- Push on `char_valid & char_ready`. `char_ready = ~full`. Data is ignored when `char_valid` is low.
- FSM states:
  - IDLE: if the FIFO is non-empty, go to POLL_AR when `POLL_EN`, else go to WR.
  - POLL_AR: `ar_valid=1`, `ar_addr=BASE_ADDR+STAT_OFFSET`. On `ar_ready`, go to POLL_R.
  - POLL_R: `r_ready=1`. On `r_valid`:
    - If `r_data[STAT_RDY_BIT]` is set, go to WR.
    - Otherwise go to POLL_AR (re-poll with no limit).
    - RRESP≠OKAY sets `err` and still follows the bit.
  - WR: `aw_valid` and `w_valid` are raised together on entry. Each is dropped independently on its own handshake. When both handshakes are complete, go to RESP.
  - RESP: `b_ready=1`. On `b_valid`:
    - Pop the FIFO.
    - Increment `tx_count`.
    - If BRESP≠OKAY, set `err`. There is no retry; the byte is dropped.
    - Go to IDLE.
- Write channel values:
  - `aw_addr = BASE_ADDR+TX_OFFSET`.
  - `w_data` = byte replicated to all four lanes.
  - `w_strb = 4'b0001 << TX_OFFSET[1:0]`.
  - `aw_prot`/`ar_prot` = 0.
- The FIFO head byte is stable from IDLE exit until the pop in RESP.
- Only one transaction is outstanding at any time.
- AXI rule: a valid, once raised, stays high with stable payload until its handshake completes.

## Timing
- Reset values:
  - `aw_valid`, `w_valid`, `ar_valid`, `b_ready`, `r_ready` = 0.
  - `err`, `tx_count` = 0.
  - FIFO empty, `char_ready=1`, `busy=0`, FSM in IDLE.
- All outputs are registered except `char_ready` and `busy` (combinational from state and FIFO count).
- Latency, push into an empty FIFO at cycle N:
  - `POLL_EN=0`: `aw_valid`/`w_valid` high at N+1.
  - `POLL_EN=1`: `ar_valid` high at N+1.
- Best-case throughput (zero-wait slave): `POLL_EN=0` gives 1 byte per 3 cycles (WR, RESP, IDLE).
- Simultaneous push and pop in the same cycle is legal at any count, including full.
- When full, a push is refused (`char_ready=0`) and a same-cycle pop does not make `char_ready` combinationally high.
- `aw_ready` and `w_ready` in different cycles: each channel's valid drops the cycle after its own handshake. RESP is entered only after the later handshake.
- A `b_valid`/`r_valid` seen outside RESP/POLL_R is ignored; `b_ready` and `r_ready` stay 0 there.
- `rst_n` low mid-transaction: all valids and readies drop asynchronously and the FIFO contents are discarded. No completion of the interrupted transaction is expected after release.

## Structure
- `axil_char_pkg`:
  - FSM state enum (IDLE, POLL_AR, POLL_R, WR, RESP).
  - `AXI_RESP_OKAY` constant.
  - Lane/strobe helper function.
- Sub-module `axil_char_fifo`: synchronous byte FIFO with `push`, `pop`, `full`, `empty`, head output, parameterised by `FIFO_DEPTH`.
- The top level holds the FSM, the per-channel handshake-done flags, `err` and `tx_count`.

## Test plan
- `POLL_EN=0`, zero-wait slave, push 0x48 then 0x69 → two writes to 0x04:
  - `w_data` 0x48484848 then 0x69696969.
  - `w_strb` 4'b0001.
  - `tx_count` = 2, `busy` = 0.
- Slave stalls `w_ready` 3 cycles after `aw_ready` → `aw_valid` drops after one cycle, `w_valid` holds with stable data, exactly one B accepted.
- `POLL_EN=1`, status returns 0, 0, then 4 → three AR reads to 0x08, then exactly one write.
- Push 6 bytes back-to-back while the slave holds `b_valid` low → `char_ready` falls after 4 accepted; all 6 bytes are eventually written in order.
- BRESP = 2'b10 on the first write → `err`=1, sticky; the next byte is still written; `tx_count` = 2.
- Assert `rst_n` low during WR → valids are 0 in the same cycle; after release `busy`=0, `tx_count`=0, and no AXI activity occurs without new pushes.
